// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder tree.
package adder_tree_pkg;

    localparam int DEFAULT_ADDER_WIDTH = 32;
    localparam int DEFAULT_NUM_INPUTS  = 8;
    localparam int MIN_INPUTS          = 2;
    localparam int MAX_INPUTS          = 64;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One level of the adder tree: pairwise adds of LANES operands into LANES/2
// registered sums one bit wider, with the valid bit travelling alongside.
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int IN_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter int LANES    = DEFAULT_NUM_INPUTS,
    parameter int SIGNED   = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                in_valid,
    input  logic [LANES*IN_WIDTH-1:0]           in_data,
    output logic                                out_valid,
    output logic [(LANES/2)*(IN_WIDTH+1)-1:0]   out_data
);

    localparam int OUT_LANES = LANES / 2;
    localparam int OW        = IN_WIDTH + 1;

    logic [OUT_LANES*OW-1:0] pair_sums;

    function automatic logic [OW-1:0] extend(input logic [IN_WIDTH-1:0] operand);
        if (SIGNED != 0) begin
            return {operand[IN_WIDTH-1], operand};
        end
        return {1'b0, operand};
    endfunction

    always_comb begin
        pair_sums = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            pair_sums[j*OW +: OW] = extend(in_data[(2*j)*IN_WIDTH +: IN_WIDTH])
                                  + extend(in_data[(2*j+1)*IN_WIDTH +: IN_WIDTH]);
        end
    end

    // Data is cleared too so the final stage presents sum = 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= pair_sums;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined reduction of NUM_INPUTS operands to one exact sum, one tree level
// per stage, with a single global stall driven by downstream backpressure.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter int NUM_INPUTS  = DEFAULT_NUM_INPUTS,
    parameter int SIGNED      = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [NUM_INPUTS*ADDER_WIDTH-1:0]            in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ADDER_WIDTH+clog2(NUM_INPUTS)-1:0]     sum
);

    localparam int LEVELS    = clog2(NUM_INPUTS);
    localparam int OUT_WIDTH = ADDER_WIDTH + LEVELS;

    if (!is_pow2(NUM_INPUTS) || (NUM_INPUTS < MIN_INPUTS) || (NUM_INPUTS > MAX_INPUTS)) begin : g_bad_num_inputs
        $error("pipelined_adder_tree: NUM_INPUTS must be a power of two in 2..64");
    end

    logic                              stall;
    logic                              stage0_valid;
    logic [NUM_INPUTS*ADDER_WIDTH-1:0] stage0_data;

    // Stall only when a finished result is blocked; bubbles never stall.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage0_valid <= 1'b0;
        end else if (!stall) begin
            stage0_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            stage0_data <= in_data;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int W     = ADDER_WIDTH + k;
        localparam int LANES = NUM_INPUTS >> k;

        logic                       stage_in_valid;
        logic [LANES*W-1:0]         stage_in;
        logic                       stage_out_valid;
        logic [(LANES/2)*(W+1)-1:0] stage_out;

        if (k == 0) begin : g_first
            assign stage_in_valid = stage0_valid;
            assign stage_in       = stage0_data;
        end else begin : g_chain
            assign stage_in_valid = g_level[k-1].stage_out_valid;
            assign stage_in       = g_level[k-1].stage_out;
        end

        adder_tree_stage #(
            .IN_WIDTH (W),
            .LANES    (LANES),
            .SIGNED   (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (!stall),
            .in_valid  (stage_in_valid),
            .in_data   (stage_in),
            .out_valid (stage_out_valid),
            .out_data  (stage_out)
        );
    end

    logic [OUT_WIDTH-1:0] final_sum;

    assign final_sum = g_level[LEVELS-1].stage_out;
    assign sum       = final_sum;
    assign out_valid = g_level[LEVELS-1].stage_out_valid;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: three configurations share one
// clock and reset; a negedge monitor checks every delivered result.
module tb_pipelined_adder_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: defaults (8 x 32 unsigned)
    logic         v0, r0, ov0, or0;
    logic [255:0] d0;
    logic [34:0]  s0;
    // dut1: 4 x 8 signed
    logic         v1, r1, ov1, or1;
    logic [31:0]  d1;
    logic [9:0]   s1;
    // dut2: 2 x 4 unsigned
    logic         v2, r2, ov2, or2;
    logic [7:0]   d2;
    logic [4:0]   s2;

    pipelined_adder_tree dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
        .out_valid(ov0), .out_ready(or0), .sum(s0)
    );

    pipelined_adder_tree #(.ADDER_WIDTH(8), .NUM_INPUTS(4), .SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .sum(s1)
    );

    pipelined_adder_tree #(.ADDER_WIDTH(4), .NUM_INPUTS(2), .SIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .sum(s2)
    );

    logic [63:0] exp_q [3][$];
    int          cyc_q [3][$];
    bit          head_seen [3];
    bit          held_v [3];
    logic [63:0] held_s [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void peek(input int i, output logic ov, output logic ordy,
                                 output logic rdy, output logic [63:0] s);
        case (i)
            0:       begin ov = ov0; ordy = or0; rdy = r0; s = 64'(s0); end
            1:       begin ov = ov1; ordy = or1; rdy = r1; s = 64'(s1); end
            default: begin ov = ov2; ordy = or2; rdy = r2; s = 64'(s2); end
        endcase
    endfunction

    task automatic set_in(input int i, input logic v, input logic [255:0] d, input logic ordy);
        case (i)
            0:       begin v0 = v; d0 = d;        or0 = ordy; end
            1:       begin v1 = v; d1 = d[31:0];  or1 = ordy; end
            default: begin v2 = v; d2 = d[7:0];   or2 = ordy; end
        endcase
    endtask

    function automatic logic [255:0] rep8(input logic [31:0] x);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = x;
        return r;
    endfunction

    // Monitor: compares every transfer against the scoreboard head.
    always @(negedge clk) begin
        logic        ov, ordy, rdy;
        logic [63:0] s;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                peek(i, ov, ordy, rdy, s);
                check($sformatf("in_ready dut%0d", i), 64'(rdy), 64'(!(ov && !ordy)));
                if (held_v[i]) begin
                    check($sformatf("held_valid dut%0d", i), 64'(ov), 64'd1);
                    check($sformatf("held_sum dut%0d", i), s, held_s[i]);
                end
                if (ov) begin
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output dut%0d: sum %0h with nothing expected (cycle %0d)", i, s, cyc);
                    end else begin
                        if (!head_seen[i] && cyc_q[i][0] >= 0)
                            check($sformatf("latency dut%0d", i), 64'(cyc), 64'(cyc_q[i][0]));
                        head_seen[i] = 1'b1;
                        if (ordy) begin
                            check($sformatf("sum dut%0d", i), s, exp_q[i].pop_front());
                            void'(cyc_q[i].pop_front());
                            head_seen[i] = 1'b0;
                        end
                    end
                end
                held_v[i] = ov && !ordy;
                held_s[i] = s;
            end
        end
    end

    // Drive one cycle (entered at posedge+1); push expectation if accepted.
    task automatic step(input int i, input logic v, input logic [255:0] d, input logic ordy,
                        input logic [63:0] exp, input int lat, output logic acc);
        logic ov, o, rdy;
        logic [63:0] s;
        set_in(i, v, d, ordy);
        @(negedge clk);
        peek(i, ov, o, rdy, s);
        acc = v && rdy;
        if (acc) begin
            exp_q[i].push_back(exp);
            cyc_q[i].push_back(lat < 0 ? -1 : cyc + lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i, input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(i, 1'b0, '0, 1'b1, '0, -1, acc);
    endtask

    task automatic drain(input int i, input string name);
        int b;
        b = 0;
        set_in(i, 1'b0, '0, 1'b1);
        while (exp_q[i].size() != 0 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (exp_q[i].size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s drain: %0d results missing, expected 0", name, exp_q[i].size());
            exp_q[i].delete();
            cyc_q[i].delete();
        end
    endtask

    task automatic do_reset(input int cycles, input logic hold_valid);
        logic        ov, ordy, rdy;
        logic [63:0] s;
        rst = 1'b1;
        set_in(0, hold_valid, rep8(32'd7), 1'b1);
        set_in(1, 1'b0, '0, 1'b1);
        set_in(2, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            cyc_q[i].delete();
            head_seen[i] = 1'b0;
            held_v[i]    = 1'b0;
        end
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(0, 1'b0, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            peek(i, ov, ordy, rdy, s);
            check($sformatf("rst_out_valid dut%0d", i), 64'(ov), 64'd0);
            check($sformatf("rst_in_ready dut%0d", i), 64'(rdy), 64'd1);
            check($sformatf("rst_sum dut%0d", i), s, 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   n, t;
        logic ordy;

        do_reset(2, 1'b0);

        // Single vector 1..8 -> 36, latency 4, then out_valid drops
        step(0, 1'b1, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, 64'd36, 4, acc);
        drain(0, "single");
        @(negedge clk);
        check("single_valid_drop", 64'(ov0), 64'd0);
        @(posedge clk);
        #1;

        // Three back-to-back all-ones vectors, one result per cycle
        for (int k = 0; k < 3; k++)
            step(0, 1'b1, {256{1'b1}}, 1'b1, 64'h7_FFFF_FFF8, 4, acc);
        drain(0, "all_ones");

        // Signed 4x8 corner cases, latency 3
        step(1, 1'b1, 256'(32'h017F_8080), 1'b1, 64'h380, 3, acc);
        step(1, 1'b1, 256'(32'h7F7F_7F7F), 1'b1, 64'h1FC, 3, acc);
        step(1, 1'b1, 256'(32'h8080_8080), 1'b1, 64'h200, 3, acc);
        step(1, 1'b1, 256'(32'hFFFF_FF05), 1'b1, 64'h002, 3, acc);
        drain(1, "signed");

        // Stream of 10 vectors with out_ready low on cycles 6..9
        n = 1;
        t = 0;
        while (n <= 10 && t < 60) begin
            ordy = !(t >= 6 && t <= 9);
            step(0, 1'b1, rep8(32'(n)), ordy, 64'(8 * n), -1, acc);
            if (acc) n++;
            t++;
        end
        check("stream_accepted", 64'(n), 64'd11);
        drain(0, "stream");

        // Reset with vectors in flight; in_valid held high during reset
        step(0, 1'b1, rep8(32'd3), 1'b1, 64'd24, 4, acc);
        step(0, 1'b1, rep8(32'd4), 1'b1, 64'd32, 4, acc);
        do_reset(1, 1'b1);
        idle(0, 5);
        step(0, 1'b1, rep8(32'd5), 1'b1, 64'd40, 4, acc);
        drain(0, "post_reset");

        // 2x4: alternating valid with bubbles, latency 2
        for (int k = 0; k < 4; k++) begin
            step(2, 1'b1, 256'(8'hFF), 1'b1, 64'h1E, 2, acc);
            idle(2, 1);
        end
        step(2, 1'b1, 256'(8'h53), 1'b1, 64'h08, 2, acc);
        drain(2, "two_lane");

        idle(0, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
